mem_arbiter: RTL and testbench

- Single-cycle arbiter sharing the one-port data RAM (execute/memory stage) among three requesters:
  - R0 = CPU data port
  - R1 = player-input writer
  - R2 = display/VGA reader
- Sits between the requesters and the RAM's en/memwrite/memread/adr/writedata/memdata pins.
- Issues at most one access per clock and routes the registered read data back with a per-requester valid strobe.
- CPU has fixed priority, bounded by a starvation counter. R1 and R2 rotate round-robin.

---
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Three-way data RAM arbiter: CPU first, starvation-bounded; R1/R2 round-robin.
// Optional per-requester grant statistics under ARB_STATS_EN.
module mem_arbiter #(
  parameter int WIDTH      = 16,
  parameter int ADDR_BITS  = 16,
  parameter int STARVE_MAX = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           req,
  input  logic [2:0]           we,
  input  logic [ADDR_BITS-1:0] adr0,
  input  logic [ADDR_BITS-1:0] adr1,
  input  logic [ADDR_BITS-1:0] adr2,
  input  logic [WIDTH-1:0]     wdata0,
  input  logic [WIDTH-1:0]     wdata1,
  input  logic [WIDTH-1:0]     wdata2,
  output logic [2:0]           gnt,
  output logic [2:0]           rvalid,
  output logic [WIDTH-1:0]     rdata,
  output logic                 mem_en,
  output logic                 mem_write,
  output logic                 mem_read,
  output logic [ADDR_BITS-1:0] mem_adr,
  output logic [WIDTH-1:0]     mem_wdata,
  input  logic [WIDTH-1:0]     mem_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]          gcnt0,
  output logic [15:0]          gcnt1,
  output logic [15:0]          gcnt2,
  output logic [15:0]          starve_events
`endif
);

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  logic       rr_q, rr_d;
  logic [7:0] starve_cnt_q, starve_cnt_d;
  logic       force_q, force_d;
  logic [2:0] rvalid_q, rvalid_d;
  logic [2:0] win;
  logic       lo_req;

  // force only masks R0 when a low-priority requester can use the slot
  always_comb begin
    win    = 3'b000;
    lo_req = req[1] | req[2];
    if (req[0] && !(force_q && lo_req)) begin
      win = 3'b001;
    end else if (!rr_q) begin
      if (req[1])      win = 3'b010;
      else if (req[2]) win = 3'b100;
    end else begin
      if (req[2])      win = 3'b100;
      else if (req[1]) win = 3'b010;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    mem_adr   = '0;
    mem_wdata = '0;
    unique case (1'b1)
      win[0]: begin
        mem_adr   = adr0;
        mem_wdata = wdata0;
      end
      win[1]: begin
        mem_adr   = adr1;
        mem_wdata = wdata1;
      end
      win[2]: begin
        mem_adr   = adr2;
        mem_wdata = wdata2;
      end
      default: ;
    endcase
    if (win != 3'b000) begin
      mem_en    = 1'b1;
      mem_write = |(win & we);
      mem_read  = ~|(win & we);
    end
  end

  always_comb begin
    rr_d         = rr_q;
    starve_cnt_d = starve_cnt_q;
    rvalid_d     = win & ~we;
    if (win[1])      rr_d = 1'b1;
    else if (win[2]) rr_d = 1'b0;
    if (win[1] || win[2] || !lo_req) starve_cnt_d = 8'd0;
    else if (win[0])                 starve_cnt_d = starve_cnt_q + 8'd1;
    force_d = (starve_cnt_d == STARVE_LIM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q         <= 1'b0;
      starve_cnt_q <= 8'd0;
      force_q      <= 1'b0;
      rvalid_q     <= 3'b000;
    end else begin
      rr_q         <= rr_d;
      starve_cnt_q <= starve_cnt_d;
      force_q      <= force_d;
      rvalid_q     <= rvalid_d;
    end
  end

  assign gnt    = win;
  assign rvalid = rvalid_q;
  assign rdata  = mem_rdata;

`ifdef ARB_STATS_EN
  logic [15:0] gcnt0_q, gcnt0_d;
  logic [15:0] gcnt1_q, gcnt1_d;
  logic [15:0] gcnt2_q, gcnt2_d;
  logic [15:0] sev_q, sev_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v,
                                           input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  always_comb begin
    gcnt0_d = sat_inc(gcnt0_q, win[0]);
    gcnt1_d = sat_inc(gcnt1_q, win[1]);
    gcnt2_d = sat_inc(gcnt2_q, win[2]);
    sev_d   = sat_inc(sev_q, force_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gcnt0_q <= 16'd0;
      gcnt1_q <= 16'd0;
      gcnt2_q <= 16'd0;
      sev_q   <= 16'd0;
    end else begin
      gcnt0_q <= gcnt0_d;
      gcnt1_q <= gcnt1_d;
      gcnt2_q <= gcnt2_d;
      sev_q   <= sev_d;
    end
  end

  assign gcnt0         = gcnt0_q;
  assign gcnt1         = gcnt1_q;
  assign gcnt2         = gcnt2_q;
  assign starve_events = sev_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with STARVE_MAX=3.
// Stats checks compile in when ARB_STATS_EN is defined.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req, we;
  logic [15:0] adr0, adr1, adr2;
  logic [15:0] wdata0, wdata1, wdata2;
  logic [2:0]  gnt, rvalid;
  logic [15:0] rdata;
  logic        mem_en, mem_write, mem_read;
  logic [15:0] mem_adr, mem_wdata, mem_rdata;
`ifdef ARB_STATS_EN
  logic [15:0] gcnt0, gcnt1, gcnt2, starve_events;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  mem_arbiter #(.WIDTH(16), .ADDR_BITS(16), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we),
    .adr0(adr0), .adr1(adr1), .adr2(adr2),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_en(mem_en), .mem_write(mem_write), .mem_read(mem_read),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef ARB_STATS_EN
    ,
    .gcnt0(gcnt0), .gcnt1(gcnt1), .gcnt2(gcnt2),
    .starve_events(starve_events)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] exp_rr [4] = '{3'b010, 3'b100, 3'b010, 3'b100};
  logic [2:0] exp_st [8] = '{3'b001, 3'b001, 3'b001, 3'b010,
                             3'b001, 3'b001, 3'b001, 3'b010};

  initial begin
    rst = 1'b1; req = '0; we = '0;
    adr0 = '0; adr1 = '0; adr2 = '0;
    wdata0 = '0; wdata1 = '0; wdata2 = '0;
    mem_rdata = '0;
    tick();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_en", 32'(mem_en), 32'h0);
    chk("rst_adr", 32'(mem_adr), 32'h0);
    rst = 1'b0;

    // R1 solo write
    req = 3'b010; we = 3'b010; adr1 = 16'h0020; wdata1 = 16'h00AB;
    #1;
    chk("w_gnt", 32'(gnt), 32'h2);
    chk("w_en", 32'(mem_en), 32'h1);
    chk("w_write", 32'(mem_write), 32'h1);
    chk("w_read", 32'(mem_read), 32'h0);
    chk("w_adr", 32'(mem_adr), 32'h20);
    chk("w_wdata", 32'(mem_wdata), 32'hAB);
    tick();

    // R2 solo read
    req = 3'b100; we = 3'b000; adr2 = 16'h0020; wdata2 = 16'h1234;
    #1;
    chk("w_no_rvalid", 32'(rvalid), 32'h0);
    chk("r_gnt", 32'(gnt), 32'h4);
    chk("r_read", 32'(mem_read), 32'h1);
    chk("r_write", 32'(mem_write), 32'h0);
    chk("r_adr", 32'(mem_adr), 32'h20);
    tick();
    req = 3'b000; mem_rdata = 16'h00AB;
    #1;
    chk("r_rvalid", 32'(rvalid), 32'h4);
    chk("r_rdata", 32'(rdata), 32'hAB);
    chk("idle_en", 32'(mem_en), 32'h0);
    chk("idle_wdata", 32'(mem_wdata), 32'h0);
    tick();
    chk("r_pulse", 32'(rvalid), 32'h0);

    // all three request: CPU wins
    req = 3'b111; we = 3'b000; adr0 = 16'h0005; adr1 = 16'h0011;
    #1;
    chk("pri_gnt", 32'(gnt), 32'h1);
    chk("pri_adr", 32'(mem_adr), 32'h5);
    tick();
    req = 3'b000;
    #1;
    chk("pri_rvalid", 32'(rvalid), 32'h1);
    chk("pri_idle", 32'(gnt), 32'h0);
    tick();

    // R1/R2 round-robin
    req = 3'b110;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr_gnt%0d", i), 32'(gnt), 32'(exp_rr[i]));
      if (i == 1) chk("rr_rvalid", 32'(rvalid), 32'h2);
      tick();
    end

    // starvation bound, STARVE_MAX=3
    req = 3'b011;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("st_gnt%0d", i), 32'(gnt), 32'(exp_st[i]));
      tick();
    end
`ifdef ARB_STATS_EN
    chk("st_gcnt0", 32'(gcnt0), 32'd7);
    chk("st_gcnt1", 32'(gcnt1), 32'd5);
    chk("st_gcnt2", 32'(gcnt2), 32'd3);
    chk("st_events", 32'(starve_events), 32'd2);
`endif
    req = 3'b000;
    tick();

    // R1 withdraws while R0 holds the bus
    req = 3'b011;
    #1;
    chk("wd_gnt_a", 32'(gnt), 32'h1);
    tick();
    req = 3'b001;
    #1;
    chk("wd_gnt_b", 32'(gnt), 32'h1);
    tick();
    req = 3'b011;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("wd_st%0d", i), 32'(gnt), 32'(exp_st[i]));
      tick();
    end

    // reset in the same cycle as an R2 read grant
    req = 3'b100; we = 3'b000; adr2 = 16'h0040; rst = 1'b1;
    #1;
    chk("rm_gnt", 32'(gnt), 32'h4);
    tick();
    rst = 1'b0; req = 3'b000;
    #1;
    chk("rm_rvalid", 32'(rvalid), 32'h0);
    chk("rm_gnt0", 32'(gnt), 32'h0);
    chk("rm_en", 32'(mem_en), 32'h0);
    chk("rm_write", 32'(mem_write), 32'h0);
    chk("rm_read", 32'(mem_read), 32'h0);
    chk("rm_adr", 32'(mem_adr), 32'h0);
`ifdef ARB_STATS_EN
    chk("rm_gcnt0", 32'(gcnt0), 32'd0);
    chk("rm_gcnt2", 32'(gcnt2), 32'd0);
    chk("rm_events", 32'(starve_events), 32'd0);
`endif
    req = 3'b110;
    #1;
    chk("rm_tie", 32'(gnt), 32'h2);
    tick();

    // rr_ptr left at R2 by that grant; reset must return it to R1
    req = 3'b000; rst = 1'b1;
    tick();
    rst = 1'b0; req = 3'b110;
    #1;
    chk("rst_rr_tie", 32'(gnt), 32'h2);
    tick();
    req = 3'b000;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
